// File: rtl/digit_scan_ctrl_if.sv
// Bus between the 7-segment scan controller and its neighbours: display data and mask
// come in, and the mux select, latched data and anode drive go out.
interface digit_scan_ctrl_if;
  logic [15:0] data_in;
  logic [3:0]  digit_en;
  logic [1:0]  sel;
  logic [15:0] data_out;
  logic [3:0]  an;
  logic        blank;
  logic        frame_tick;

  modport master (
    output data_in, digit_en,
    input  sel, data_out, an, blank, frame_tick
  );

  modport slave (
    input  data_in, digit_en,
    output sel, data_out, an, blank, frame_tick
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with frame-boundary data capture and
// per-slot anode dead-time. Every output is a register loaded from the next-state decode.
module digit_scan_ctrl #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  digit_scan_ctrl_if.slave bus
);

  localparam int unsigned     CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CYCLES);

  logic [CNT_W-1:0] tick_cnt, tick_nxt;
  logic [1:0]       sel_q, sel_nxt;
  logic [15:0]      data_q, data_nxt;
  logic [3:0]       en_q, en_nxt;
  logic [3:0]       an_q, an_nxt;
  logic             blank_q, blank_nxt;
  logic             frame_q, frame_nxt;
  logic             in_dead_c;

  // Dead window at the start of each slot, evaluated on the upcoming tick count.
  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign in_dead_c = 1'b0;
  end else begin : g_dead
    assign in_dead_c = (tick_nxt < DEAD_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      sel_q    <= 2'd0;
      data_q   <= 16'h0000;
      en_q     <= 4'b0000;
      an_q     <= 4'b1111;
      blank_q  <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      tick_cnt <= tick_nxt;
      sel_q    <= sel_nxt;
      data_q   <= data_nxt;
      en_q     <= en_nxt;
      an_q     <= an_nxt;
      blank_q  <= blank_nxt;
      frame_q  <= frame_nxt;
    end
  end

  // frame_q is high in the last cycle of slot 3, so it doubles as the capture strobe.
  always_comb begin
    tick_nxt  = tick_cnt + CNT_W'(1);
    sel_nxt   = sel_q;
    data_nxt  = data_q;
    en_nxt    = en_q;
    an_nxt    = 4'b1111;
    blank_nxt = 1'b1;
    frame_nxt = 1'b0;

    if (tick_cnt == TICK_LAST) begin
      tick_nxt = '0;
      sel_nxt  = sel_q + 2'd1;
    end

    if (frame_q) begin
      data_nxt = bus.data_in;
      en_nxt   = bus.digit_en;
    end

    blank_nxt = ~en_nxt[sel_nxt];
    frame_nxt = (sel_nxt == 2'd3) && (tick_nxt == TICK_LAST);

    if (!in_dead_c && !blank_nxt) begin
      an_nxt[sel_nxt] = 1'b0;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.data_out   = data_q;
  assign bus.an         = an_q;
  assign bus.blank      = blank_q;
  assign bus.frame_tick = frame_q;

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

- Time-multiplexed scan controller for the 4-digit 7-segment display path.
- Sits directly upstream of the 16-to-4 nibble mux:
  - drives the mux's 2-bit digit select and its 16-bit data word;
  - drives the active-low anode lines in lockstep.
- Latches new display data only at frame boundaries, so digits never tear.
- Inserts a programmable anode dead-time at each digit change to suppress ghosting.

## Interface
Parameters:
- TICK_DIV, default 100000: clock cycles per digit slot; legal range ≥ 2.
- DEAD_CYCLES, default 1000: cycles at the start of each slot with all anodes off; legal range 0 ≤ DEAD_CYCLES < TICK_DIV.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  16  display word; nibble k belongs to digit k, with digit 0 = bits [3:0].
- digit_en  input  4  per-digit enable mask; bit k = 1 lights digit k.
- sel  output  2  current digit index; feeds the mux selector.
- data_out  output  16  frame-latched display word; feeds the mux data input.
- an  output  4  anode enables, active-low; 1 = digit off.
- blank  output  1  high when the current slot's digit is masked off.
- frame_tick  output  1  one-cycle pulse in the last cycle of slot 3.

## Operation
State registers:
- tick_cnt, range 0..TICK_DIV-1.
- sel, 2 bits.
- data_out, 16 bits.
- en_q, 4 bits (latched copy of digit_en).

Per-cycle behaviour:
- tick_cnt increments every cycle. At TICK_DIV-1 it wraps to 0 and sel increments modulo 4 (3 → 0).
- frame_tick = (sel == 3) && (tick_cnt == TICK_DIV-1), decoded from registers.
- On the edge ending a frame_tick cycle:
  - data_out <= data_in;
  - en_q <= digit_en.
  - No other capture point exists. Mid-frame changes on data_in/digit_en are ignored until the next boundary.
- blank = ~en_q[sel].
- an is decoded from registers only; there is no combinational path from data_in or digit_en.
  - If tick_cnt < DEAD_CYCLES or blank = 1: an = 4'b1111.
  - Otherwise an[sel] = 0 and all other bits = 1.
- At most one anode is low at any time.

Reset (synchronous), effective on the edge where reset is sampled high:
- tick_cnt = 0, sel = 0, data_out = 16'h0000, en_q = 4'b0000.
- Resulting outputs: an = 4'b1111, blank = 1, frame_tick = 0.
- The first frame after reset is therefore fully dark. The first capture happens at the end of that frame.
- Reset asserted mid-slot or mid-frame discards all progress; no partial capture is made.

Arithmetic and widths:
- tick_cnt width is $clog2(TICK_DIV).
- sel wraps naturally in 2 bits.
- No saturation logic.

## Timing
- Cycle 0 is the first cycle with reset low. tick_cnt = 0 and sel = 0 in cycle 0.
- Slot length is exactly TICK_DIV cycles; frame length is 4·TICK_DIV cycles.
- sel changes on the edge after tick_cnt = TICK_DIV-1.
  - Slot k occupies cycles k·TICK_DIV .. (k+1)·TICK_DIV-1, modulo the frame.
- Capture latency: data_in sampled in the frame_tick cycle appears on data_out in the next cycle, which is the first cycle of slot 0.
- an for slot k goes low at cycle k·TICK_DIV + DEAD_CYCLES. It returns high at the slot boundary, in the same cycle sel changes.
- DEAD_CYCLES = 0: the anode is on for the whole slot, and the sel and an transitions coincide.
- All outputs are glitch-free register decodes and are valid for the entire cycle.

## Test plan
All scenarios use TICK_DIV = 8 and DEAD_CYCLES = 2 unless stated.

1. Reset: hold reset 3 cycles with data_in = 16'h1234 and digit_en = 4'b1111.
   - During and after reset: sel = 0, an = 1111, data_out = 0000, frame_tick = 0.
   - After release: sel = 1 at cycle 8, frame_tick high only in cycle 31.
2. Frame capture: data_in = 16'h1234 and digit_en = 4'b1111, held constant.
   - data_out = 16'h1234 from cycle 32.
   - Cycles 34–39: an = 1110. Cycles 42–47: an = 1101.
   - Cycles 32–33 and 40–41: an = 1111.
3. Anti-tear: with step 2 running, set data_in = 16'hABCD at cycle 45.
   - data_out stays 1234 through cycle 63 and becomes ABCD at cycle 64.
4. Masking: digit_en = 4'b0101, latched at a frame boundary.
   - In the following frame: blank = 1 in slots 1 and 3, and an = 1111 for those whole slots.
   - an = 1110 in slot 0 and 1011 in slot 2, each after 2 dead cycles.
5. Reset mid-operation: assert reset for 1 cycle while sel = 2 and tick_cnt = 5.
   - The next cycle shows all reset values and data_out = 0000.
   - The next frame_tick occurs 32 cycles after release.
6. DEAD_CYCLES = 0, all digits enabled:
   - an is low for all 8 cycles of each slot.
   - Exactly one bit is low in every cycle after the first capture; a checker asserts this throughout.
